fta_to_wb_bridge: RTL and testbench

- Responder-side bridge: accepts FTA bus requests as an FTA slave and executes each one as a classic Wishbone master cycle.
- Returns one FTA response per request, carrying the tid, read data and error status.
- Lets legacy Wishbone peripherals sit behind the FTA interconnect.
- Small request FIFO decouples FTA request bursts from slow Wishbone targets.

---
 rtl/fta_bus_pkg.sv | 9 +
 rtl/fta_bus_interface.sv | 26 ++
 rtl/fta_req_fifo.sv | 52 +++++
 rtl/fta_to_wb_bridge.sv | 141 ++++++++++++++
 tb/tb_fta_to_wb_bridge.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: shared FSM state type, tid width, default timeout and request packing width
package fta_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} fta_wb_state_t;
  localparam int TIDW = 8;
  localparam int TO_DEFAULT = 1023;
  function automatic int req_w(input int wid);
    return 1 + wid / 8 + 32 + wid + TIDW;
  endfunction
endpackage

// File: rtl/fta_bus_interface.sv
// fta_bus_interface: FTA request/response bundle with initiator and responder views
interface fta_bus_interface import fta_bus_pkg::*; #(
  parameter int WID = 256
);
  typedef struct packed {
    logic            cyc;
    logic            we;
    logic [WID/8-1:0] sel;
    logic [31:0]     adr;
    logic [WID-1:0]  data1;
    logic [TIDW-1:0] tid;
  } req_t;
  typedef struct packed {
    logic            ack;
    logic            err;
    logic            rty;
    logic            full;
    logic [TIDW-1:0] tid;
    logic [31:0]     adr;
    logic [WID-1:0]  dat;
  } resp_t;
  req_t  req;
  resp_t resp;
  modport master (output req, input resp);
  modport slave (input req, output resp);
endinterface

// File: rtl/fta_req_fifo.sv
// fta_req_fifo: request FIFO; empty lags count by one cycle, almost_full is registered
module fta_req_fifo import fta_bus_pkg::*; #(
  parameter int WID   = 256,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [req_w(WID)-1:0]     din_i,
  output logic [req_w(WID)-1:0]     dout_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      almost_full_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [req_w(WID)-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_q, empty_d, afull_q, afull_d, do_push, do_pop;
  always_comb begin
    full_o  = cnt_q == (AW+1)'(DEPTH);
    do_push = push_i && !full_o;
    do_pop  = pop_i && cnt_q != '0;
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_d = cnt_q == '0;
    afull_d = cnt_d >= (AW+1)'(DEPTH - 1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wp_q] <= din_i;
  assign dout_o        = mem[rp_q];
  assign empty_o       = empty_q;
  assign almost_full_o = afull_q;
  assign count_o       = cnt_q;
endmodule

// File: rtl/fta_to_wb_bridge.sv
// fta_to_wb_bridge: FTA responder to classic Wishbone master; FTA_TO_WB_TIMEOUT_EN adds a WAIT timeout
module fta_to_wb_bridge import fta_bus_pkg::*; #(
  parameter int WID       = 256,
  parameter int DEPTH     = 4,
  parameter int TO_CYCLES = TO_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fta_bus_interface.slave  fta_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [WID/8-1:0] sel_o,
  output logic [31:0]      adr_o,
  output logic [WID-1:0]   dat_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [WID-1:0]   dat_i,
  output logic             busy_o,
  output logic             ovf_o
);
  localparam int SW = WID / 8;
  localparam int FW = req_w(WID);
  fta_wb_state_t state_q, state_d;
  logic cyc_q, cyc_d, we_q, we_d, err_q, err_d, ack_q, ack_d, ovf_q, ovf_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [WID-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [TIDW-1:0] tid_q, tid_d;
  logic [FW-1:0] fin, fout;
  logic f_we, empty, full, afull, pop, done, to_hit;
  logic [SW-1:0] f_sel;
  logic [31:0] f_adr;
  logic [WID-1:0] f_dat;
  logic [TIDW-1:0] f_tid;
  logic [$clog2(DEPTH):0] count;
  assign fin = {fta_i.req.we, fta_i.req.sel, fta_i.req.adr, fta_i.req.data1, fta_i.req.tid};
  assign {f_we, f_sel, f_adr, f_dat, f_tid} = fout;
  fta_req_fifo #(.WID(WID), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(fta_i.req.cyc), .pop_i(pop), .din_i(fin),
    .dout_o(fout), .empty_o(empty), .full_o(full), .almost_full_o(afull), .count_o(count)
  );
  assign done = ack_i || err_i;
`ifdef FTA_TO_WB_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES + 1);
  logic [TOW-1:0] to_q, to_d;
  always_comb begin
    to_d   = state_q == WAIT ? to_q + 1'b1 : '0;
    to_hit = state_q == WAIT && !done && to_q == TOW'(TO_CYCLES - 1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) to_q <= '0;
    else to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    tid_d   = tid_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q || (fta_i.req.cyc && full);
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = WAIT;
        cyc_d   = 1'b1;
        we_d    = f_we;
        sel_d   = f_sel;
        adr_d   = f_adr;
        wdat_d  = f_we ? f_dat : '0;
        tid_d   = f_tid;
      end
      WAIT: if (done || to_hit) begin
        state_d = RESP;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        rdat_d  = (!we_q && ack_i && !err_i && !to_hit) ? dat_i : '0;
        err_d   = err_i || to_hit;
      end
      RESP: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      tid_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      tid_q   <= tid_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    fta_i.resp      = '0;
    fta_i.resp.ack  = ack_q;
    fta_i.resp.err  = err_q;
    fta_i.resp.full = afull;
    fta_i.resp.tid  = tid_q;
    fta_i.resp.adr  = adr_q;
    fta_i.resp.dat  = rdat_q;
  end
  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign we_o   = we_q;
  assign sel_o  = sel_q;
  assign adr_o  = adr_q;
  assign dat_o  = wdat_q;
  assign ovf_o  = ovf_q;
  assign busy_o = count != '0 || state_q != IDLE;
endmodule

// File: tb/tb_fta_to_wb_bridge.sv
// tb_fta_to_wb_bridge: directed self-checking bench for the FTA to Wishbone bridge
module tb_fta_to_wb_bridge;
  import fta_bus_pkg::*;
  localparam int WID = 256;
  localparam int SW  = WID / 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fta_bus_interface #(.WID(WID)) fta ();
  logic cyc_o, stb_o, we_o, busy_o, ovf_o;
  logic ack_i = 1'b0, err_i = 1'b0;
  logic [SW-1:0] sel_o;
  logic [31:0] adr_o;
  logic [WID-1:0] dat_o, dat_i = '0;
  int checks = 0, errors = 0;
  logic [7:0] rtid[$];
  logic rerr[$];
  logic [WID-1:0] rdat[$];
  fta_to_wb_bridge #(.WID(WID), .DEPTH(4), .TO_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fta_i(fta), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );
  always @(negedge clk) if (fta.resp.ack === 1'b1) begin
    rtid.push_back(fta.resp.tid);
    rerr.push_back(fta.resp.err);
    rdat.push_back(fta.resp.dat);
  end
  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic we, input logic [SW-1:0] sel, input logic [31:0] adr,
                      input logic [WID-1:0] d, input logic [7:0] tid);
    fta.req.cyc = 1'b1; fta.req.we = we; fta.req.sel = sel;
    fta.req.adr = adr; fta.req.data1 = d; fta.req.tid = tid;
    @(negedge clk);
    fta.req.cyc = 1'b0;
  endtask
  task automatic wait_cyc();
    for (int k = 0; k < 30 && cyc_o !== 1'b1; k++) @(negedge clk);
    chk("wait_cyc", cyc_o, 1);
  endtask
  task automatic serve(input int lat, input logic [WID-1:0] d, input logic e);
    wait_cyc();
    repeat (lat - 1) @(negedge clk);
    ack_i = !e; err_i = e; dat_i = d;
    @(negedge clk);
    ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    chk("serve_drop", cyc_o, 0);
  endtask
  task automatic clear_q();
    rtid.delete(); rerr.delete(); rdat.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] exp_tid [5];
    int hi;
    exp_tid = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24};
    fta.req = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_rack", fta.resp.ack, 0);
    chk("rst_rfull", fta.resp.full, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, '1, 32'h1000, '0, 8'h05);
    chk("load_cyc_n0", cyc_o, 0);
    @(negedge clk);
    chk("load_cyc_n1", cyc_o, 0);
    @(negedge clk);
    chk("load_cyc_n2", cyc_o, 1);
    chk("load_stb", stb_o, 1);
    chk("load_adr", adr_o, 32'h1000);
    chk("load_sel", sel_o, {SW{1'b1}});
    chk("load_we", we_o, 0);
    chk("load_dato", dat_o, 0);
    @(negedge clk);
    chk("load_cyc_n3", cyc_o, 1);
    ack_i = 1'b1; dat_i = {32{8'hA5}};
    @(negedge clk);
    ack_i = 1'b0; dat_i = '0;
    chk("load_cyc_n4", cyc_o, 0);
    chk("load_rack_n4", fta.resp.ack, 0);
    @(negedge clk);
    chk("load_rack_n5", fta.resp.ack, 1);
    chk("load_tid", fta.resp.tid, 8'h05);
    chk("load_rdat", fta.resp.dat, {32{8'hA5}});
    chk("load_err", fta.resp.err, 0);
    chk("load_radr", fta.resp.adr, 32'h1000);
    @(negedge clk);
    chk("load_rack_n6", fta.resp.ack, 0);
    chk("load_busy", busy_o, 0);
    send(1'b1, 32'h0F, 32'h2000, 256'h1234, 8'h06);
    repeat (2) @(negedge clk);
    chk("st_cyc", cyc_o, 1);
    chk("st_we", we_o, 1);
    chk("st_dato", dat_o, 256'h1234);
    chk("st_sel", sel_o, 32'h0F);
    ack_i = 1'b1; dat_i = '1;
    @(negedge clk);
    ack_i = 1'b0; dat_i = '0;
    chk("st_cyc_drop", cyc_o, 0);
    chk("st_we_drop", we_o, 0);
    chk("st_sel_drop", sel_o, 0);
    @(negedge clk);
    chk("st_rack", fta.resp.ack, 1);
    chk("st_tid", fta.resp.tid, 8'h06);
    chk("st_rdat", fta.resp.dat, 0);
    chk("st_err", fta.resp.err, 0);
    @(negedge clk);
    clear_q();
    send(1'b0, '1, 32'h3000, '0, 8'h10);
    wait_cyc();
    for (int i = 0; i < 6; i++) begin
      fta.req.cyc = 1'b1; fta.req.we = 1'b0; fta.req.sel = '1;
      fta.req.adr = 32'h3100 + 32'(i); fta.req.tid = 8'h21 + 8'(i);
      @(negedge clk);
      chk("burst_full", fta.resp.full, i >= 2);
      if (i == 3) chk("burst_ovf_pre", ovf_o, 0);
    end
    fta.req.cyc = 1'b0;
    chk("burst_ovf", ovf_o, 1);
    for (int k = 0; k < 5; k++) serve(5, 256'(k + 1), 1'b0);
    repeat (4) @(negedge clk);
    chk("burst_nresp", rtid.size(), 5);
    for (int k = 0; k < 5 && k < rtid.size(); k++) begin
      chk("burst_tid", rtid[k], exp_tid[k]);
      chk("burst_dat", rdat[k], 256'(k + 1));
    end
    chk("burst_ovf_sticky", ovf_o, 1);
    clear_q();
    send(1'b0, '1, 32'h4000, '0, 8'h31);
    send(1'b0, '1, 32'h4004, '0, 8'h32);
    serve(2, '1, 1'b1);
    serve(2, 256'h77, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_nresp", rtid.size(), 2);
    if (rtid.size() == 2) begin
      chk("err_tid0", rtid[0], 8'h31);
      chk("err_err0", rerr[0], 1);
      chk("err_dat0", rdat[0], 0);
      chk("err_tid1", rtid[1], 8'h32);
      chk("err_err1", rerr[1], 0);
      chk("err_dat1", rdat[1], 256'h77);
    end
    clear_q();
    send(1'b0, '1, 32'h4100, '0, 8'h41);
    wait_cyc();
`ifdef FTA_TO_WB_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("to_hold", cyc_o, 1);
    @(negedge clk);
    chk("to_drop", cyc_o, 0);
    ack_i = 1'b1; dat_i = '1;
    repeat (2) @(negedge clk);
    ack_i = 1'b0; dat_i = '0;
    repeat (4) @(negedge clk);
    chk("to_nresp", rtid.size(), 1);
    if (rtid.size() == 1) begin
      chk("to_tid", rtid[0], 8'h41);
      chk("to_err", rerr[0], 1);
      chk("to_dat", rdat[0], 0);
    end
`else
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (cyc_o === 1'b1) hi++;
    end
    chk("noto_hold", hi, 100);
    chk("noto_nresp", rtid.size(), 0);
`endif
    clear_q();
    send(1'b0, '1, 32'h5000, '0, 8'h51);
    send(1'b0, '1, 32'h5004, '0, 8'h52);
    wait_cyc();
    chk("mid_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", cyc_o, 0);
    chk("arst_stb", stb_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_ovf", ovf_o, 0);
    chk("arst_rfull", fta.resp.full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_nresp", rtid.size(), 0);
    chk("arst_cyc_after", cyc_o, 0);
    chk("arst_busy_after", busy_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
